traffic_phase_ctrl: RTL and testbench

- Phase sequencer for a two-road intersection (main/side).
- Owns a phase state machine and a per-phase 7-bit down-timer.
- Drives lamp outputs, pedestrian-walk and countdown-display outputs.
- Adds pedestrian-request early termination and an emergency all-red override on top of the fixed 80-cycle base plan.

---
 rtl/traffic_phase_ctrl.sv | 156 +++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer: fixed base plan with a per-phase
// down-timer, pedestrian early cut of main green and an emergency all-red hold.
module traffic_phase_ctrl #(
    parameter int MG      = 40,
    parameter int MY      = 5,
    parameter int AR      = 2,
    parameter int SG      = 26,
    parameter int SY      = 5,
    parameter int PED_CUT = 9
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic       ped_walk,
    output logic [6:0] remain,
    output logic [2:0] phase,
    output logic       cycle_done
);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_1   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_2   = 3'd5,
        EMERG       = 3'd6
    } phase_t;

    // Timer reload values are duration-1 so remain==0 marks the last cycle.
    localparam logic [6:0] MG_LD = 7'(MG - 1);
    localparam logic [6:0] MY_LD = 7'(MY - 1);
    localparam logic [6:0] AR_LD = 7'(AR - 1);
    localparam logic [6:0] SG_LD = 7'(SG - 1);
    localparam logic [6:0] SY_LD = 7'(SY - 1);
    localparam logic [6:0] CUT   = 7'(PED_CUT);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    phase_t     state_q, state_d;
    logic [6:0] remain_q, remain_d;
    logic       ped_q, ped_d;
    logic       last;
    logic       entering_sg;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q  <= MAIN_GREEN;
            remain_q <= MG_LD;
            ped_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            ped_q    <= ped_d;
        end
    end

    assign last = (remain_q == 7'd0);

    // Emergency overrides everything; otherwise the timer advances the plan.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q - 7'd1;
        if (emerg) begin
            state_d  = EMERG;
            remain_d = 7'd0;
        end else begin
            case (state_q)
                MAIN_GREEN: begin
                    if (last) begin
                        state_d  = MAIN_YELLOW;
                        remain_d = MY_LD;
                    end else if (ped_q && (remain_q > CUT)) begin
                        remain_d = CUT;
                    end
                end
                MAIN_YELLOW: begin
                    if (last) begin
                        state_d  = ALL_RED_1;
                        remain_d = AR_LD;
                    end
                end
                ALL_RED_1: begin
                    if (last) begin
                        state_d  = SIDE_GREEN;
                        remain_d = SG_LD;
                    end
                end
                SIDE_GREEN: begin
                    if (last) begin
                        state_d  = SIDE_YELLOW;
                        remain_d = SY_LD;
                    end
                end
                SIDE_YELLOW: begin
                    if (last) begin
                        state_d  = ALL_RED_2;
                        remain_d = AR_LD;
                    end
                end
                ALL_RED_2: begin
                    if (last) begin
                        state_d  = MAIN_GREEN;
                        remain_d = MG_LD;
                    end
                end
                EMERG: begin
                    state_d  = ALL_RED_2;
                    remain_d = AR_LD;
                end
                default: begin
                    state_d  = EMERG;
                    remain_d = 7'd0;
                end
            endcase
        end
    end

    // Requests are served by the side green, so they are dropped while it is
    // running or about to start.
    assign entering_sg = (state_d == SIDE_GREEN) && (state_q != SIDE_GREEN);

    always_comb begin
        ped_d = ped_q;
        if (entering_sg)
            ped_d = 1'b0;
        else if (ped_req && (state_q != SIDE_GREEN))
            ped_d = 1'b1;
    end

    always_comb begin
        main_lamp = LAMP_R;
        side_lamp = LAMP_R;
        case (state_q)
            MAIN_GREEN:  main_lamp = LAMP_G;
            MAIN_YELLOW: main_lamp = LAMP_Y;
            SIDE_GREEN:  side_lamp = LAMP_G;
            SIDE_YELLOW: side_lamp = LAMP_Y;
            default: begin
                main_lamp = LAMP_R;
                side_lamp = LAMP_R;
            end
        endcase
    end

    assign ped_walk   = (state_q == SIDE_GREEN);
    assign remain     = remain_q;
    assign phase      = state_q;
    assign cycle_done = (state_q == ALL_RED_2) && last;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: phase-table reference model checked every
// cycle, directed plan scenarios with literal pins, then randomized traffic.
module tb_traffic_phase_ctrl;

    localparam int MG = 40, MY = 5, AR = 2, SG = 26, SY = 5, PED_CUT = 9;

    logic       clk1, rst, ped_req, emerg;
    logic [2:0] main_lamp, side_lamp, phase;
    logic       ped_walk, cycle_done;
    logic [6:0] remain;

    traffic_phase_ctrl #(.MG(MG), .MY(MY), .AR(AR), .SG(SG), .SY(SY), .PED_CUT(PED_CUT)) dut (
        .clk1(clk1), .rst(rst), .ped_req(ped_req), .emerg(emerg),
        .main_lamp(main_lamp), .side_lamp(side_lamp), .ped_walk(ped_walk),
        .remain(remain), .phase(phase), .cycle_done(cycle_done)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Plan tables indexed by phase code (6 = emergency).
    int dur      [0:5] = '{MG, MY, AR, SG, SY, AR};
    int main_tab [0:6] = '{1, 2, 4, 4, 4, 4, 4};
    int side_tab [0:6] = '{4, 4, 4, 1, 2, 4, 4};

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int mp, mr;
    bit mpend;

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        mp = 0; mr = MG - 1; mpend = 1'b0;
    endtask

    // One clock of the plan: emergency first, release into AR2, expiry moves
    // to the next phase in the 6-entry ring, pending pedestrian trims MG.
    task automatic model_step(input bit p, input bit e);
        int np, nr;
        np = mp;
        nr = mr - 1;
        if (e) begin
            np = 6; nr = 0;
        end else if (mp == 6) begin
            np = 5; nr = AR - 1;
        end else if (mr == 0) begin
            np = (mp + 1) % 6; nr = dur[np] - 1;
        end else if (mp == 0 && mpend && mr > PED_CUT) begin
            nr = PED_CUT;
        end
        if (np == 3 && mp != 3) mpend = 1'b0;
        else if (p && mp != 3)  mpend = 1'b1;
        mp = np;
        mr = nr;
    endtask

    task automatic compare_model();
        chk("phase",      int'(phase),      mp);
        chk("remain",     int'(remain),     mr);
        chk("main_lamp",  int'(main_lamp),  main_tab[mp]);
        chk("side_lamp",  int'(side_lamp),  side_tab[mp]);
        chk("ped_walk",   int'(ped_walk),   (mp == 3) ? 1 : 0);
        chk("cycle_done", int'(cycle_done), (mp == 5 && mr == 0) ? 1 : 0);
    endtask

    task automatic run_cycle(input bit p, input bit e);
        ped_req = p;
        emerg   = e;
        compare_model();
        @(posedge clk1);
        model_step(p, e);
        @(negedge clk1);
        cyc++;
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_main"},   int'(main_lamp), 1);
        chk({nm, "_side"},   int'(side_lamp), 4);
        chk({nm, "_remain"}, int'(remain),    39);
        chk({nm, "_walk"},   int'(ped_walk),  0);
        chk({nm, "_phase"},  int'(phase),     0);
        chk({nm, "_done"},   int'(cycle_done), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; ped_req = 1'b0; emerg = 1'b0;
        model_reset();
        #1;
        check_reset_vals("rst");
        @(negedge clk1);
        @(negedge clk1);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Reset between clock edges; called at a falling edge.
    task automatic async_reset(input string nm);
        ped_req = 1'b0; emerg = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_vals(nm);
        model_reset();
        @(negedge clk1);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        bit em;
        rst = 1'b1; ped_req = 1'b0; emerg = 1'b0;
        model_reset();

        // Base plan, no inputs.
        do_reset();
        for (int c = 0; c <= 80; c++) begin
            if (c == 39) chk("s1_mg_end", int'(phase), 0);
            if (c == 40) chk("s1_my",     int'(phase), 1);
            if (c == 45) chk("s1_ar1",    int'(phase), 2);
            if (c == 47) chk("s1_sg",     int'(phase), 3);
            if (c == 73) chk("s1_sy",     int'(phase), 4);
            if (c == 78) chk("s1_done78", int'(cycle_done), 0);
            if (c == 79) chk("s1_done79", int'(cycle_done), 1);
            if (c == 80) chk("s1_rem80",  int'(remain), 39);
            run_cycle(1'b0, 1'b0);
        end

        // Pedestrian request early in MG cuts it.
        do_reset();
        for (int c = 0; c <= 48; c++) begin
            if (c == 6)  chk("s2_rem6",  int'(remain), 33);
            if (c == 7)  chk("s2_rem7",  int'(remain), 9);
            if (c == 16) chk("s2_rem16", int'(remain), 0);
            if (c == 17) chk("s2_my17",  int'(phase), 1);
            if (c == 24) chk("s2_walk",  int'(ped_walk), 1);
            run_cycle(c == 5, 1'b0);
        end

        // Late request does not change timing.
        do_reset();
        for (int c = 0; c <= 44; c++) begin
            if (c == 39) chk("s3_mg39", int'(phase), 0);
            if (c == 40) chk("s3_my40", int'(phase), 1);
            run_cycle(c == 35, 1'b0);
        end

        // Requests during SG are ignored; next MG is full length.
        do_reset();
        for (int c = 0; c <= 121; c++) begin
            if (c == 100) chk("s4_rem100", int'(remain), 19);
            if (c == 119) chk("s4_mg119",  int'(phase), 0);
            if (c == 120) chk("s4_my120",  int'(phase), 1);
            run_cycle(c == 50 || c == 60 || c == 72, 1'b0);
        end

        // Emergency hold and release through AR2.
        do_reset();
        for (int c = 0; c <= 35; c++) begin
            if (c == 21) chk("s5_em21",   int'(phase), 6);
            if (c == 21) chk("s5_main21", int'(main_lamp), 4);
            if (c == 25) chk("s5_rem25",  int'(remain), 0);
            if (c == 30) chk("s5_em30",   int'(phase), 6);
            if (c == 31) chk("s5_ar2",    int'(phase), 5);
            if (c == 31) chk("s5_rem31",  int'(remain), 1);
            if (c == 32) chk("s5_done32", int'(cycle_done), 1);
            if (c == 33) chk("s5_mg33",   int'(remain), 39);
            run_cycle(1'b0, c >= 20 && c <= 29);
        end

        // Emergency together with a request: request survives into next MG.
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            if (c == 11) chk("s6_em11",  int'(phase), 6);
            if (c == 16) chk("s6_ar16",  int'(phase), 5);
            if (c == 18) chk("s6_rem18", int'(remain), 39);
            if (c == 19) chk("s6_rem19", int'(remain), 9);
            run_cycle(c == 10, c >= 10 && c <= 14);
        end

        // Reset in the middle of side green, between edges.
        do_reset();
        for (int c = 0; c < 55; c++) run_cycle(1'b0, 1'b0);
        chk("s7_in_sg", int'(phase), 3);
        async_reset("s7");
        for (int c = 0; c < 5; c++) run_cycle(1'b0, 1'b0);

        // Randomized traffic.
        do_reset();
        em = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (em) em = ($urandom_range(0, 7) != 0);
            else    em = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 899) == 0) async_reset("rnd_rst");
            run_cycle($urandom_range(0, 19) == 0, em);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
